// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bus of the serial subtractor; mode exists only with ADD_MODE_EN.
interface serial_subtractor_if
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             Cout;
  logic             V;
  logic             busy;
  logic             done;
`ifdef ADD_MODE_EN
  logic             mode;
`endif

  modport master (
    output start, A, B,
    input  D, Cout, V, busy, done
`ifdef ADD_MODE_EN
    , output mode
`endif
  );

  modport slave (
    input  start, A, B,
    output D, Cout, V, busy, done
`ifdef ADD_MODE_EN
    , input mode
`endif
  );

endinterface

// File: rtl/serial_subtractor_full_adder.sv
// Single one-bit full-adder cell shared by every bit position of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B (LSB first) through one full-adder cell, start/busy/done framed.
// Optional macro ADD_MODE_EN adds a mode input selecting A + B.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int              CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic w_busy;
  logic w_done;
  logic w_accept;
  logic w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_res_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_d;
  logic             r_cout;
  logic             r_v;

  logic             w_sub;
  logic             w_sub_in;
  logic             w_fa_b;
  logic             w_sum;
  logic             w_carry_out;
  logic [WIDTH-1:0] w_res_full;
  logic             w_v;

  // w_sub: operation of the in-flight op; w_sub_in: operation being requested now.
`ifdef ADD_MODE_EN
  logic r_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_mode <= bus.mode;
    end
  end

  assign w_sub    = ~r_mode;
  assign w_sub_in = ~bus.mode;
`else
  assign w_sub    = 1'b1;
  assign w_sub_in = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (r_cnt == LAST_CNT) w_state_next = DONE;
      DONE:    w_state_next = bus.start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: w_accept = bus.start;
      RUN: begin
        w_busy = 1'b1;
        w_last = (r_cnt == LAST_CNT);
      end
      DONE: begin
        w_done   = 1'b1;
        w_accept = bus.start;
      end
      default: ;
    endcase
  end

  assign w_fa_b = r_b_sh[0] ^ w_sub;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (w_fa_b),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_carry_out)
  );

  assign w_res_full = {w_sum, r_res_sh};

  // Operands of unlike sign (subtract) or like sign (add) overflow when the sign flips.
  assign w_v = ((r_a_msb ^ r_b_msb) == w_sub) & (w_sum != r_a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_d      <= '0;
      r_cout   <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= bus.A;
      r_b_sh   <= bus.B;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= w_sub_in;
      r_a_msb  <= bus.A[WIDTH-1];
      r_b_msb  <= bus.B[WIDTH-1];
    end else if (w_busy) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_full[WIDTH-1:1];
      r_carry  <= w_carry_out;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_d    <= w_res_full;
        r_cout <= w_carry_out;
        r_v    <= w_v;
      end
    end
  end

  assign bus.D    = r_d;
  assign bus.Cout = r_cout;
  assign bus.V    = r_v;
  assign bus.busy = w_busy;
  assign bus.done = w_done;

endmodule
